// File: rtl/pn_injector_pkg.sv
// pn_injector_pkg: time-stamp encoding shared with the permutation-network
// arbiters, plus the head state type of the injector.
package pn_injector_pkg;

    // Timestamp width that both the injector and the arbiters agree on.
    localparam int PN_TIME_WIDTH = 8;

    // Empty-slot code: a lane whose time field is 0 carries no flit.
    localparam int PN_TS_EMPTY = 0;

    // First value of the time counter after reset and after a wrap.
    localparam int PN_TS_START = 1;

    typedef enum logic {
        HS_EMPTY,
        HS_WAIT
    } head_st_t;

endpackage

// File: rtl/pn_ts_fifo.sv
// pn_ts_fifo: DEPTH-entry synchronous FIFO of {data, time} entries.
// Ports: push/pop strobes, head entry, full/empty flags and entry count.
module pn_ts_fifo #(
    parameter int DW    = 32,
    parameter int TW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DW-1:0]            push_data,
    input  logic [TW-1:0]            push_time,
    input  logic                     pop,
    output logic [DW-1:0]            head_data,
    output logic [TW-1:0]            head_time,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_d [DEPTH];
    logic [TW-1:0] mem_t [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt;

    // Storage carries no reset; validity is tracked by cnt alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_d[wptr] <= push_data;
            mem_t[wptr] <= push_time;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head_data = mem_d[rptr];
    assign head_time = mem_t[rptr];
    assign full      = (cnt == (AW+1)'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;

endmodule

// File: rtl/pn_injector.sv
// pn_injector: stamps PE flits with a creation time, queues them and injects
// the head into a free router lane; flags a head that has waited too long.
// Ports: enq_* from the PE, slot_free/inj_* to the router, starve, occupancy.
module pn_injector
    import pn_injector_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int TIME_WIDTH   = PN_TIME_WIDTH,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enq_valid,
    input  logic [DATA_WIDTH-1:0]    enq_data,
    output logic                     enq_ready,
    input  logic                     slot_free,
    output logic                     inj_valid,
    output logic [DATA_WIDTH-1:0]    inj_data,
    output logic [TIME_WIDTH-1:0]    inj_time,
    output logic                     starve,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [TIME_WIDTH-1:0] TS_MAX = '1;

    logic [TIME_WIDTH-1:0] tcnt;
    logic [WW-1:0]         wcnt;
    logic [WW-1:0]         wcnt_nx;
    head_st_t              state;
    head_st_t              state_nx;

    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [DATA_WIDTH-1:0] head_data;
    logic [TIME_WIDTH-1:0] head_time;
    logic [$clog2(DEPTH):0] count;

    assign enq_ready = !full;
    assign push      = enq_valid && enq_ready;
    assign inj_valid = !empty && slot_free;
    assign pop       = inj_valid;
    assign inj_data  = inj_valid ? head_data : '0;
    assign inj_time  = inj_valid ? head_time : TIME_WIDTH'(PN_TS_EMPTY);
    assign occupancy = count;

    pn_ts_fifo #(
        .DW    (DATA_WIDTH),
        .TW    (TIME_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (enq_data),
        .push_time (tcnt),
        .pop       (pop),
        .head_data (head_data),
        .head_time (head_time),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Skips 0 on wrap so a stamp never looks like an empty slot.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tcnt <= TIME_WIDTH'(PN_TS_START);
        end else if (tcnt == TS_MAX) begin
            tcnt <= TIME_WIDTH'(PN_TS_START);
        end else begin
            tcnt <= tcnt + TIME_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= HS_EMPTY;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        unique case (state)
            HS_EMPTY: begin
                wcnt_nx = '0;
                if (push) state_nx = HS_WAIT;
            end
            HS_WAIT: begin
                if (pop) begin
                    // A new head starts its wait from zero.
                    wcnt_nx = '0;
                    if (count == 1 && !push) state_nx = HS_EMPTY;
                end else if (wcnt < WW'(STARVE_LIMIT)) begin
                    wcnt_nx = wcnt + WW'(1);
                end
            end
            default: begin
                state_nx = HS_EMPTY;
                wcnt_nx  = '0;
            end
        endcase
    end

    assign starve = (state == HS_WAIT) && (wcnt >= WW'(STARVE_LIMIT));

endmodule

// File: doc/pn_injector.md
Name: pn_injector

Overview:
- Injection unit feeding the permutation-network router of one bless_mc node.
- Accepts flits from the local PE into a small queue and stamps each flit with a creation time.
- Presents the queue head as an injected flit whenever the router signals a free input slot.
- Generates the time fields that the permutation-network arbiters compare: smaller non-zero value = older = higher priority; value 0 = empty slot.

Parameters:
- DATA_WIDTH, 32, flit payload width.
- TIME_WIDTH, `TIME_WIDTH (8), timestamp width; value taken from global.vh.
- DEPTH, 4, queue entries; power of two, at least 2.
- STARVE_LIMIT, 16, head wait cycles before starve is asserted.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- enq_valid  in  1  PE offers a flit.
- enq_data  in  DATA_WIDTH  PE flit payload.
- enq_ready  out  1  queue can accept a flit this cycle.
- slot_free  in  1  router has an empty input lane this cycle.
- inj_valid  out  1  flit injected this cycle.
- inj_data  out  DATA_WIDTH  injected payload.
- inj_time  out  TIME_WIDTH  injected flit's creation stamp; 0 when inj_valid=0.
- starve  out  1  head flit has waited at least STARVE_LIMIT cycles.
- occupancy  out  $clog2(DEPTH)+1  current queue entry count.

Behaviour:
- Reset (reset_n=0 at a clock edge), also when asserted mid-operation:
  - Queue emptied, pointers cleared, occupancy=0.
  - Time counter set to 1; wait counter set to 0.
  - Outputs: enq_ready=1, inj_valid=0, inj_data=0, inj_time=0, starve=0.
  - Queued flits are discarded. No partial injection is possible because injection is combinational from registered state.
- Time counter:
  - Increments by 1 every cycle.
  - Sequence runs 1, 2, ..., 2^TIME_WIDTH-1, then wraps to 1.
  - Never holds 0, so a stamped flit never carries the empty-slot code.
- Enqueue:
  - Fires when enq_valid && enq_ready; writes {enq_data, current counter} at the tail.
  - enq_ready = (occupancy != DEPTH), derived from registered occupancy only.
  - No bypass: a flit enqueued in cycle N is injectable at the earliest in cycle N+1.
- Inject:
  - inj_valid = (occupancy != 0) && slot_free, combinational.
  - inj_data and inj_time come from the head entry; when inj_valid=0 both are driven to 0.
  - The head is popped at the clock edge when inj_valid=1. The router must consume the flit in that same cycle; there is no back-pressure beyond slot_free.
- Simultaneous enqueue and pop:
  - Occupancy is unchanged.
  - When full, enq_ready=0 even if a pop occurs that cycle.
  - When empty with enqueue only, the new entry becomes head next cycle.
- Pointers wrap modulo DEPTH; occupancy is held in a separate counter.
- Head state machine, 2 states:
  - EMPTY: occupancy=0. Go to WAIT on an enqueue.
  - WAIT: head present.
    - Pop with occupancy>1 (after the pop): stay in WAIT and reset the wait counter to 0.
    - Pop of the last entry with no simultaneous enqueue: go to EMPTY.
    - No pop: wait counter increments, saturating at STARVE_LIMIT.
- starve:
  - Registered: starve = (state==WAIT && wait counter >= STARVE_LIMIT).
  - Clears on the cycle after the starving head is popped.

Decomposition:
- Shared package / global.vh holds:
  - `TIME_WIDTH.
  - The empty-slot code (0).
  - The counter restart value (1).
  These are shared with the permutation-network arbiters, so both ends agree on the encoding.
- One natural sub-module: pn_ts_fifo, a DEPTH-entry synchronous FIFO of {data, time} with full/empty/count outputs.
- Time counter, state machine and starvation logic stay in pn_injector.

Test Plan:
- Reset then idle 3 cycles -> enq_ready=1, inj_valid=0, inj_time=0, occupancy=0.
- Enqueue A when counter=5; slot_free=1 from the next cycle -> inj_valid=1 exactly one cycle later, inj_data=A, inj_time=5; occupancy back to 0.
- Enqueue 4 flits with slot_free=0 (DEPTH=4) -> enq_ready=0 after the 4th. A 5th enq_valid is ignored. Then slot_free=1 for 4 cycles -> flits injected in order with non-decreasing stamps.
- Force the counter to 255 (TIME_WIDTH=8) and enqueue on two consecutive cycles -> stamps 255 then 1; 0 never appears on inj_time while inj_valid=1.
- One flit queued, slot_free=0 for 16 cycles -> starve rises when the wait counter reaches 16. slot_free=1 -> flit injected, starve=0 the next cycle.
- Queue 3 flits, assert reset_n=0 for one edge mid-stream with slot_free=1 -> next cycle occupancy=0, inj_valid=0, counter restarts at 1.
